// File: rtl/nand_logic_sequencer.sv
// Multi-cycle bitwise logic unit: every 2-input op is built from repeated passes
// through one shared NAND array, with results staged in scratch registers T0-T2.
module nand_logic_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_T2, SRC_R} src_e;
    typedef enum logic [1:0] {DST_T0, DST_T1, DST_T2, DST_R} dst_e;

    state_e           state, state_nxt;
    logic [2:0]       step;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, t0_r, t1_r, t2_r, r_r;

    src_e             sel_x, sel_y;
    dst_e             dst;
    logic [WIDTH-1:0] x, y, nand_out;

    // Pass schedule: which operands feed the array and where its output lands.
    always_comb begin
        sel_x = SRC_A;
        sel_y = SRC_A;
        dst   = DST_R;
        case (op_r)
            3'd0: begin sel_x = SRC_A; sel_y = SRC_B; dst = DST_R; end
            3'd1: begin
                case (step)
                    3'd0:    begin sel_x = SRC_A;  sel_y = SRC_B;  dst = DST_T0; end
                    default: begin sel_x = SRC_T0; sel_y = SRC_T0; dst = DST_R;  end
                endcase
            end
            3'd2, 3'd3: begin
                case (step)
                    3'd0:    begin sel_x = SRC_A;  sel_y = SRC_A;  dst = DST_T0; end
                    3'd1:    begin sel_x = SRC_B;  sel_y = SRC_B;  dst = DST_T1; end
                    3'd2:    begin
                        sel_x = SRC_T0;
                        sel_y = SRC_T1;
                        dst   = (op_r == 3'd3) ? DST_T2 : DST_R;
                    end
                    default: begin sel_x = SRC_T2; sel_y = SRC_T2; dst = DST_R;  end
                endcase
            end
            3'd4, 3'd5: begin
                case (step)
                    3'd0:    begin sel_x = SRC_A;  sel_y = SRC_B;  dst = DST_T0; end
                    3'd1:    begin sel_x = SRC_A;  sel_y = SRC_T0; dst = DST_T1; end
                    3'd2:    begin sel_x = SRC_B;  sel_y = SRC_T0; dst = DST_T2; end
                    3'd3:    begin
                        sel_x = SRC_T1;
                        sel_y = SRC_T2;
                        dst   = (op_r == 3'd5) ? DST_T0 : DST_R;
                    end
                    default: begin sel_x = SRC_T0; sel_y = SRC_T0; dst = DST_R;  end
                endcase
            end
            3'd6: begin sel_x = SRC_A; sel_y = SRC_A; dst = DST_R; end
            default: begin
                case (step)
                    3'd0:    begin sel_x = SRC_A;  sel_y = SRC_A;  dst = DST_T0; end
                    default: begin sel_x = SRC_T0; sel_y = SRC_T0; dst = DST_R;  end
                endcase
            end
        endcase
    end

    always_comb begin
        x = a_r;
        case (sel_x)
            SRC_A:   x = a_r;
            SRC_B:   x = b_r;
            SRC_T0:  x = t0_r;
            SRC_T1:  x = t1_r;
            SRC_T2:  x = t2_r;
            SRC_R:   x = r_r;
            default: x = a_r;
        endcase
    end

    always_comb begin
        y = a_r;
        case (sel_y)
            SRC_A:   y = a_r;
            SRC_B:   y = b_r;
            SRC_T0:  y = t0_r;
            SRC_T1:  y = t1_r;
            SRC_T2:  y = t2_r;
            SRC_R:   y = r_r;
            default: y = a_r;
        endcase
    end

    assign nand_out = ~(x & y);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)      state_nxt = RUN;
            RUN:     if (dst == DST_R)  state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_c = r_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            t0_r  <= '0;
            t1_r  <= '0;
            t2_r  <= '0;
            r_r   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                a_r  <= in_a;
                b_r  <= in_b;
                op_r <= op;
                step <= '0;
            end else if (state == RUN) begin
                step <= step + 3'd1;
                case (dst)
                    DST_T0:  t0_r <= nand_out;
                    DST_T1:  t1_r <= nand_out;
                    DST_T2:  t2_r <= nand_out;
                    default: r_r  <= nand_out;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nand_logic_sequencer.sv
// Directed and randomized checks of nand_logic_sequencer against a bitwise reference.
module tb_nand_logic_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_c;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;

    nand_logic_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic int npass(input logic [2:0] o);
        case (o)
            3'd0, 3'd6: return 1;
            3'd1, 3'd7: return 2;
            3'd2:       return 3;
            3'd3, 3'd4: return 4;
            default:    return 5;
        endcase
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int stall, input bit poke);
        int cyc;
        in_valid  = 1'b1;
        op        = o;
        in_a      = a;
        in_b      = b;
        out_ready = (stall == 0);
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        op       = ~o;
        chk("busy_run", busy, 1);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 16);
        chk("latency", cyc, npass(o));
        chk("result", out_c, exp);
        for (int s = 0; s < stall; s++) begin
            in_valid = poke;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_c", out_c, exp);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("back_idle", in_ready, 1);
        chk("idle_keep_c", out_c, exp);
    endtask

    logic [31:0] exp_q[$];
    int          acc_cyc[$];
    int          results;

    initial begin
        logic [31:0] ra, rb, re;
        logic [2:0]  ro;
        int          cyc;
        bit          acc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_c", out_c, 0);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);

        // Op sweep with hand-computed results
        do_op(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0);
        do_op(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0);
        do_op(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0);
        do_op(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0);
        do_op(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0);
        do_op(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 0, 0);
        do_op(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0);
        do_op(3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 0, 0);

        // Backpressure with in_valid held high while stalled
        do_op(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 10, 1);
        chk("bp_out_valid_low", out_valid, 0);

        // Operands are zeroed right after acceptance inside do_op
        do_op(3'd1, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 0, 0);

        // Reset in the middle of an XNOR
        in_valid = 1'b1; op = 3'd5; in_a = 32'hAAAA5555; in_b = 32'h0F0F0F0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_c", out_c, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("post_rst_no_output", out_valid, 0);
        chk("post_rst_out_c", out_c, 0);
        do_op(3'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0);

        // Back-to-back: OR, AND, OR, AND with in_valid never dropped
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = 3'd2; in_a = 32'h00FF1234; in_b = 32'h0F0F0000;
        results = 0;
        cyc = 0;
        while ((acc_cyc.size() < 4 || results < 4) && cyc < 60) begin
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (out_valid) begin
                results++;
                if (exp_q.size() == 0) chk("b2b_spurious", out_c, 32'hDEADBEEF ^ out_c ^ 32'h1);
                else chk("b2b_result", out_c, exp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(ref_op(op, in_a, in_b));
                acc_cyc.push_back(cyc);
                if (acc_cyc.size() == 4) in_valid = 1'b0;
                op   = (op == 3'd2) ? 3'd1 : 3'd2;
                in_a = in_a + 32'h01010101;
                in_b = ~in_b;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 4);
        chk("b2b_results", results, 4);
        chk("b2b_leftover", exp_q.size(), 0);
        if (acc_cyc.size() == 4) begin
            chk("b2b_gap_or", acc_cyc[1] - acc_cyc[0], 5);
            chk("b2b_gap_and", acc_cyc[2] - acc_cyc[1], 4);
            chk("b2b_gap_or2", acc_cyc[3] - acc_cyc[2], 5);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_idle", in_ready, 1);

        // Random ops with random stalls
        for (int i = 0; i < 1000; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            re = ref_op(ro, ra, rb);
            do_op(ro, ra, rb, re, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nand_logic_sequencer.md
Name: nand_logic_sequencer

Overview:
- Multi-cycle controller that computes the full set of 2-input bitwise logic ops using one shared WIDTH-bit NAND array.
- It sequences operand muxes and scratch registers so the array performs one NAND pass per cycle.
- It sits between the decode/issue stage and the register writeback in the NAND-built datapath.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- WIDTH, 32, operand/result bit width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- op  input  3  operation code (see Behaviour).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_c  output  WIDTH  result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Datapath: exactly one internal NAND array, nand_out = ~(x & y).
  - x and y are muxed from {A, B, T0, T1, T2, R}.
  - A and B are captured at accept. T0–T2 are scratch registers; R is the result register.
  - Each RUN cycle writes nand_out to one destination register.
  - No other logic function may compute the result.
- Op codes and pass schedules (N = pass count):
  - 0 NAND, N=1: R=n(A,B).
  - 1 AND, N=2: T0=n(A,B); R=n(T0,T0).
  - 2 OR, N=3: T0=n(A,A); T1=n(B,B); R=n(T0,T1).
  - 3 NOR, N=4: OR schedule with the third pass writing T2; R=n(T2,T2).
  - 4 XOR, N=4: T0=n(A,B); T1=n(A,T0); T2=n(B,T0); R=n(T1,T2).
  - 5 XNOR, N=5: XOR schedule with the fourth pass writing T0; R=n(T0,T0).
  - 6 NOT A, N=1: R=n(A,A).
  - 7 BUF A, N=2: T0=n(A,A); R=n(T0,T0).
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1.
    - On in_valid at an edge: capture A, B, op; step counter=0; go to RUN.
  - RUN: in_ready=0.
    - Each edge executes pass [step] and increments step.
    - The edge executing pass N-1 loads R and moves to DONE.
  - DONE: out_valid=1, out_c=R, in_ready=0.
    - On out_ready at an edge: go to IDLE.
    - No new request is accepted in the same cycle; one bubble is required between transactions.
- Latency:
  - Acceptance edge is E0; passes occur at E1..EN.
  - out_valid rises immediately after edge EN, i.e. N cycles after acceptance.
  - Minimum issue interval is N+2 cycles.
- Input stability: in_a, in_b and op are sampled only at the acceptance edge. Changes during RUN/DONE have no effect.
- Output hold: out_c holds R until the next acceptance. out_c is don't-care-free: it keeps the last result while in IDLE.
- Backpressure: DONE persists indefinitely while out_ready=0. out_c is stable throughout.
- Edge cases:
  - in_valid in RUN/DONE is ignored; the requester must hold it until it sees in_ready.
  - out_ready while not in DONE is ignored.
- Reset (asynchronous, active-high, any state including mid-RUN):
  - State goes to IDLE; step counter, A, B, T0–T2 and R go to 0.
  - Outputs: out_valid=0, busy=0, out_c=0, in_ready=1 once rst deasserts.
  - An in-flight operation is discarded with no output.
- Width rule: all ops are purely bitwise; there is no carry or cross-bit interaction. WIDTH=1 must work.

Test Plan:
- Op sweep: for op 0..7, in_a=0xF0F0F0F0, in_b=0xFF00FF00, out_ready=1 → out_c and pass count:
  - NAND 0x0FFF0FFF, 1 pass.
  - AND 0xF000F000, 2 passes.
  - OR 0xFFF0FFF0, 3 passes.
  - NOR 0x000F000F, 4 passes.
  - XOR 0x0FF00FF0, 4 passes.
  - XNOR 0xF00FF00F, 5 passes.
  - NOT 0x0F0F0F0F, 1 pass.
  - BUF 0xF0F0F0F0, 2 passes.
  - In each case out_valid rises exactly N cycles after acceptance.
- Backpressure: XOR with out_ready=0 for 10 cycles → out_valid stays 1 and out_c stays 0x0FF00FF0; in_ready=0 and in_valid is ignored throughout. Raising out_ready → one cycle later in IDLE with in_ready=1.
- Operand change: accept AND with a=0xFFFFFFFF, b=0x12345678, then drive a=0, b=0 on the next cycle → out_c=0x12345678.
- Reset mid-op: assert rst during pass 2 of XNOR → out_valid=0, busy=0, out_c=0, in_ready=1 after deassert. A following NAND with a=0, b=0 → out_c=0xFFFFFFFF after 1 pass.
- Back-to-back: hold in_valid=1 continuously with alternating OR/AND requests, out_ready=1 → each accepted only in IDLE. Issue intervals are 5 and 4 cycles; no request is lost or duplicated (scoreboard check).
- Random: 1000 random op/a/b with random out_ready stalls → out_c matches the bitwise reference model.
